// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared encodings and parameter helpers for the chunked multiplier control path
package multiplier_pkg;
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_MULT  = 4'b0010,
        S_DRAIN = 4'b0100,
        S_DONE  = 4'b1000
    } state_e;
    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;
    function automatic int num_steps(input int xlen, input int chunk_w);
        return xlen / chunk_w;
    endfunction
    function automatic int sa_w(input int xlen, input int chunk_w);
        return $clog2(num_steps(xlen, chunk_w));
    endfunction
    function automatic bit params_ok(input int xlen, input int chunk_w, input int pipe_depth);
        return chunk_w > 0 && xlen % chunk_w == 0 && xlen / chunk_w >= 2 &&
               pipe_depth >= 0 && pipe_depth <= 7;
    endfunction
endpackage

// File: rtl/mult_cp_counter.sv
// mult_cp_counter: up-counter 0..MAX with clear, enable and terminal count; wraps to 0 after MAX
module mult_cp_counter #(
    parameter int MAX = 3,
    localparam int W = MAX > 0 ? $clog2(MAX + 1) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc_o  = cnt_q == W'(MAX);
    assign cnt_o = cnt_q;
    always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tc_o ? '0 : cnt_q + W'(1);
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/multiplier_cp_v2.sv
// multiplier_cp_v2: control path sequencing NUM_STEPS partial-product steps then PIPE_DEPTH drain cycles
module multiplier_cp_v2
    import multiplier_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CHUNK_W = 8,
    parameter int PIPE_DEPTH = 1,
    localparam int NUM_STEPS = num_steps(XLEN, CHUNK_W),
    localparam int SA_W = sa_w(XLEN, CHUNK_W)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            ack_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            reg_A_en_o,
    output logic            reg_B_en_o,
    output logic            AC_clr_o,
    output logic            AC_en_o,
    output logic            en_pipe_o,
    output logic            mux_B_sel_o,
    output logic            rol_en_o,
    output logic [SA_W-1:0] shift_amount_o,
    output logic            sign_a_o,
    output logic            sign_b_o,
    output logic            hi_sel_o,
    output logic            done_o
);
    localparam int DR_MAX = PIPE_DEPTH > 0 ? PIPE_DEPTH - 1 : 0;
    localparam int DR_W = DR_MAX > 0 ? $clog2(DR_MAX + 1) : 1;
    if (!params_ok(XLEN, CHUNK_W, PIPE_DEPTH)) begin : g_bad_params
        $error("multiplier_cp_v2: illegal XLEN/CHUNK_W/PIPE_DEPTH combination");
    end
    state_e state_q, state_d;
    op_e op_q;
    logic run, accept, mult_en, drain_en, step_tc, drain_tc, active;
    logic [SA_W-1:0] step_q;
    logic [DR_W-1:0] drain_cnt_unused;
    logic [2:0] mode;
    assign run      = !stall_i && !flush_i;
    assign accept   = state_q == S_IDLE && start_i && run;
    assign mult_en  = state_q == S_MULT && run;
    assign drain_en = state_q == S_DRAIN && run;
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_MULT : S_IDLE;
            S_MULT:  state_d = mult_en && step_tc ? (PIPE_DEPTH > 0 ? S_DRAIN : S_DONE) : S_MULT;
            S_DRAIN: state_d = drain_en && drain_tc ? S_DONE : S_DRAIN;
            S_DONE:  state_d = run && ack_i ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
        end else begin
            state_q <= state_d;
            if (accept) op_q <= op_e'(op_i);
        end
    end
    mult_cp_counter #(.MAX(NUM_STEPS - 1)) u_step (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i || accept),
        .en_i  (mult_en),
        .cnt_o (step_q),
        .tc_o  (step_tc)
    );
    mult_cp_counter #(.MAX(DR_MAX)) u_drain (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .en_i  (drain_en),
        .cnt_o (drain_cnt_unused),
        .tc_o  (drain_tc)
    );
    // mode bits are {sign_a, sign_b, hi_sel}
    always_comb mode = op_q == OP_MUL ? 3'b000 : op_q == OP_MULH ? 3'b111 :
                       op_q == OP_MULHSU ? 3'b101 : 3'b001;
    assign active         = state_q == S_MULT || state_q == S_DRAIN || state_q == S_DONE;
    assign {sign_a_o, sign_b_o, hi_sel_o} = active ? mode : 3'b000;
    assign ready_o        = state_q == S_IDLE;
    assign busy_o         = state_q == S_MULT || state_q == S_DRAIN;
    assign reg_A_en_o     = accept;
    assign AC_clr_o       = accept;
    assign reg_B_en_o     = accept || mult_en;
    assign AC_en_o        = mult_en;
    assign mux_B_sel_o    = mult_en;
    assign rol_en_o       = mult_en;
    assign en_pipe_o      = mult_en || drain_en;
    assign shift_amount_o = state_q == S_MULT ? step_q : '0;
    assign done_o         = state_q == S_DONE && !flush_i;
endmodule
